// File: rtl/remote_cmd_arbiter.sv
// remote_cmd_arbiter: shares one RemoteComm command transmitter between
// NUM_REQ requesters. Round-robin arbitration, one transaction at a time:
// latch the winner's command, pulse snd_cmd, wait for cmd_snt and (optionally)
// the response byte with a timeout, then hand done/resp back to the owner.
module remote_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter bit WAIT_RESP    = 1'b1,
    parameter int RESP_TIMEOUT = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [7:0]              resp_out,
    output logic                    resp_err,
    output logic                    busy,
    output logic                    snd_cmd,
    output logic [15:0]             cmd,
    input  logic                    cmd_snt,
    input  logic [7:0]              resp,
    input  logic                    resp_rdy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SENDING,
        S_WAIT_RSP,
        S_COMPLETE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;         // highest-priority requester for the next pick
    logic [PTR_W-1:0]   owner;       // requester that owns the current transaction
    logic [CNT_W-1:0]   cnt;         // cycles spent waiting for the response
    logic [CNT_W-1:0]   cnt_next;
    logic               timeout_hit;
    logic               resp_seen;   // response already arrived while still sending
    logic               timed_out;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;

    // Round-robin pick: first requesting index at or above ptr, wrapping around.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    // Saturating wait counter; the timeout fires on the edge where it reaches
    // RESP_TIMEOUT-1, so done lands exactly RESP_TIMEOUT cycles after cmd_snt.
    always_comb begin
        cnt_next    = (cnt == CNT_W'(RESP_TIMEOUT)) ? cnt : cnt + 1'b1;
        timeout_hit = (int'(cnt_next) >= RESP_TIMEOUT - 1);
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (pick_valid) state_next = S_LAUNCH;
            S_LAUNCH:   state_next = S_SENDING;
            S_SENDING: begin
                if (cmd_snt) begin
                    if (!WAIT_RESP || resp_seen || resp_rdy) state_next = S_COMPLETE;
                    else                                     state_next = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: if (resp_rdy || timeout_hit) state_next = S_COMPLETE;
            S_COMPLETE: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction without telling RemoteComm.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Transaction datapath: grant/command latch, response capture, pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            owner     <= '0;
            ptr       <= '0;
            cmd       <= 16'h0000;
            snd_cmd   <= 1'b0;
            resp_out  <= 8'h00;
            cnt       <= '0;
            resp_seen <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            // Registered off the LAUNCH state: snd_cmd appears two edges after
            // the request is sampled, with cmd already stable.
            snd_cmd <= (state == S_LAUNCH);
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt   <= NUM_REQ'(1) << pick_idx;
                        owner <= pick_idx;
                        cmd   <= req_cmd[16*pick_idx +: 16];
                    end
                end
                S_SENDING: begin
                    if (resp_rdy) begin
                        resp_seen <= 1'b1;
                        resp_out  <= resp;
                    end
                end
                S_WAIT_RSP: begin
                    cnt <= cnt_next;
                    if (resp_rdy) begin
                        resp_out <= resp;
                    end else if (timeout_hit) begin
                        resp_out  <= 8'h00;
                        timed_out <= 1'b1;
                    end
                end
                S_COMPLETE: begin
                    gnt       <= '0;
                    ptr       <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    cnt       <= '0;
                    resp_seen <= 1'b0;
                    timed_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the state; gnt is still held during COMPLETE.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_COMPLETE) ? gnt : '0;
        resp_err = (state == S_COMPLETE) && timed_out;
    end

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Directed testbench for remote_cmd_arbiter: a main instance with response
// waiting (timeout shortened to 50) and a second instance with WAIT_RESP=0.
// RemoteComm is modelled by tasks that pulse cmd_snt / resp_rdy.
module tb_remote_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req = '0;
    logic [63:0] req_cmd = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  resp_out;
    logic        resp_err, busy, snd_cmd;
    logic [15:0] cmd;
    logic        cmd_snt = 1'b0;
    logic [7:0]  resp = '0;
    logic        resp_rdy = 1'b0;

    logic [3:0]  req0 = '0;
    logic [63:0] req_cmd0 = '0;
    logic [3:0]  gnt0, done0;
    logic [7:0]  resp_out0;
    logic        resp_err0, busy0, snd_cmd0;
    logic [15:0] cmd0;
    logic        cmd_snt0 = 1'b0;
    logic [7:0]  resp0 = '0;
    logic        resp_rdy0 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    remote_cmd_arbiter #(.NUM_REQ(4), .WAIT_RESP(1'b1), .RESP_TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .gnt(gnt), .done(done),
        .resp_out(resp_out), .resp_err(resp_err), .busy(busy), .snd_cmd(snd_cmd),
        .cmd(cmd), .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy)
    );

    remote_cmd_arbiter #(.NUM_REQ(4), .WAIT_RESP(1'b0), .RESP_TIMEOUT(50)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .req_cmd(req_cmd0), .gnt(gnt0), .done(done0),
        .resp_out(resp_out0), .resp_err(resp_err0), .busy(busy0), .snd_cmd(snd_cmd0),
        .cmd(cmd0), .cmd_snt(cmd_snt0), .resp(resp0), .resp_rdy(resp_rdy0)
    );

    // Continuous check: grant is one-hot or idle, done only to the granted requester.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(gnt) || ((done & ~gnt) != 4'b0)) begin
                errors++;
                $display("FAIL gnt_onehot: gnt=%b done=%b required one-hot gnt covering done", gnt, done);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; req0 = '0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        cmd_snt0 = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic wait_snd(output int n);
        n = 0;
        while (!snd_cmd && n < 20) begin tick; n++; end
        checks++;
        if (!snd_cmd) begin errors++; $display("FAIL snd_wait: snd_cmd=%b required 1 within 20 cycles", snd_cmd); end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done == 4'b0 && n < 200) begin tick; n++; end
        checks++;
        if (done == 4'b0) begin errors++; $display("FAIL done_wait: done=%b required nonzero within 200 cycles", done); end
    endtask

    task automatic pulse_snt;
        cmd_snt = 1'b1; tick; cmd_snt = 1'b0;
    endtask

    task automatic pulse_resp(input logic [7:0] v);
        resp = v; resp_rdy = 1'b1; tick; resp_rdy = 1'b0;
    endtask

    // One full transaction against the RemoteComm model; returns what was observed.
    task automatic serve(input bit give_resp, input logic [7:0] rv,
                         output logic [15:0] c, output logic [3:0] g, output logic [3:0] d,
                         output logic [7:0] r, output logic e);
        int n;
        wait_snd(n);
        c = cmd; g = gnt;
        repeat (3) tick;
        pulse_snt;
        if (give_resp) begin tick; pulse_resp(rv); end
        wait_done(n);
        d = done; r = resp_out; e = resp_err;
    endtask

    task automatic test_reset;
        rst = 1'b1; #1;
        checks++; if (gnt !== 4'b0)      begin errors++; $display("FAIL rst_gnt: got %b required 0000", gnt); end
        checks++; if (done !== 4'b0)     begin errors++; $display("FAIL rst_done: got %b required 0000", done); end
        checks++; if (resp_out !== 8'h00) begin errors++; $display("FAIL rst_resp_out: got %h required 00", resp_out); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (snd_cmd !== 1'b0)  begin errors++; $display("FAIL rst_snd_cmd: got %b required 0", snd_cmd); end
        checks++; if (cmd !== 16'h0000)  begin errors++; $display("FAIL rst_cmd: got %h required 0000", cmd); end
        do_reset;
        // Stray RemoteComm strobes in IDLE must be ignored.
        cmd_snt = 1'b1; resp = 8'hEE; resp_rdy = 1'b1; tick;
        cmd_snt = 1'b0; resp_rdy = 1'b0; tick;
        checks++; if (busy !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL idle_strobe: busy=%b done=%b required 0/0000", busy, done); end
        checks++; if (resp_out !== 8'h00) begin errors++; $display("FAIL idle_strobe_resp: got %h required 00", resp_out); end
    endtask

    task automatic test_single;
        int n;
        do_reset;
        req_cmd = 64'h0000_0000_0000_ABCD;
        req = 4'b0001;
        wait_snd(n);
        checks++; if (n != 2)           begin errors++; $display("FAIL single_latency: got %0d required 2", n); end
        checks++; if (cmd !== 16'hABCD) begin errors++; $display("FAIL single_cmd: got %h required abcd", cmd); end
        checks++; if (gnt !== 4'b0001)  begin errors++; $display("FAIL single_gnt: got %b required 0001", gnt); end
        req = 4'b0000;
        repeat (3) tick;
        pulse_snt;
        tick;
        pulse_resp(8'hA5);
        checks++; if (done !== 4'b0001)  begin errors++; $display("FAIL single_done: got %b required 0001", done); end
        checks++; if (resp_out !== 8'hA5) begin errors++; $display("FAIL single_resp: got %h required a5", resp_out); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", resp_err); end
        tick;
        checks++; if (done !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after: done=%b gnt=%b busy=%b required 0000/0000/0", done, gnt, busy); end
    endtask

    task automatic test_round_robin;
        logic [15:0] exp_cmd [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
        logic [15:0] c; logic [3:0] g, d, eg; logic [7:0] r; logic e;
        do_reset;
        req_cmd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1'b1, 8'h10 + 8'(i), c, g, d, r, e);
            eg = 4'b0001 << (i % 4);
            checks++; if (c !== exp_cmd[i]) begin errors++; $display("FAIL rr_cmd[%0d]: got %h required %h", i, c, exp_cmd[i]); end
            checks++; if (g !== eg)         begin errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", i, g, eg); end
            checks++; if (d !== eg)         begin errors++; $display("FAIL rr_done[%0d]: got %b required %b", i, d, eg); end
            checks++; if (r !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rr_resp[%0d]: got %h required %h", i, r, 8'h10 + 8'(i)); end
            if (i == 4) req = 4'b0000;
            tick;
            checks++; if (busy !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL rr_idle_gap[%0d]: busy=%b gnt=%b required 0/0000", i, busy, gnt); end
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [15:0] c; logic [3:0] g, d; logic [7:0] r; logic e;
        do_reset;
        req_cmd = {16'h0000, 16'h9999, 16'h5555, 16'h7070};
        req = 4'b0001;
        serve(1'b1, 8'h77, c, g, d, r, e);
        checks++; if (r !== 8'h77) begin errors++; $display("FAIL to_pre_resp: got %h required 77", r); end
        req = 4'b0010;
        wait_snd(n);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_gnt: got %b required 0010", gnt); end
        req = 4'b0000;
        repeat (2) tick;
        cmd_snt = 1'b1; tick; cmd_snt = 1'b0;
        n = 1;
        while (done == 4'b0 && n < 200) begin tick; n++; end
        checks++; if (n != 50)          begin errors++; $display("FAIL to_latency: got %0d required 50", n); end
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL to_done: got %b required 0010", done); end
        checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", resp_err); end
        checks++; if (resp_out !== 8'h00) begin errors++; $display("FAIL to_resp: got %h required 00", resp_out); end
        tick;
        checks++; if (resp_err !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL to_pulse: err=%b done=%b required 0/0000", resp_err, done); end
        req = 4'b0100;
        serve(1'b1, 8'h99, c, g, d, r, e);
        checks++; if (g !== 4'b0100 || c !== 16'h9999) begin errors++; $display("FAIL to_next: gnt=%b cmd=%h required 0100/9999", g, c); end
        checks++; if (r !== 8'h99 || e !== 1'b0) begin errors++; $display("FAIL to_next_resp: resp=%h err=%b required 99/0", r, e); end
        req = 4'b0000;
    endtask

    task automatic test_early_resp;
        int n;
        do_reset;
        req_cmd = {16'h0000, 16'h0000, 16'h1234, 16'h3C3C};
        req = 4'b0001;
        wait_snd(n);
        req = 4'b0000;
        tick;
        pulse_resp(8'h3C);
        checks++; if (busy !== 1'b1 || done !== 4'b0) begin errors++; $display("FAIL early_hold: busy=%b done=%b required 1/0000", busy, done); end
        tick;
        pulse_snt;
        checks++; if (done !== 4'b0001)   begin errors++; $display("FAIL early_done: got %b required 0001", done); end
        checks++; if (resp_out !== 8'h3C) begin errors++; $display("FAIL early_resp: got %h required 3c", resp_out); end
        checks++; if (resp_err !== 1'b0)  begin errors++; $display("FAIL early_err: got %b required 0", resp_err); end
        tick;
        // Response arriving on the very cycle the timeout would fire.
        req = 4'b0010;
        wait_snd(n);
        req = 4'b0000;
        tick;
        cmd_snt = 1'b1; tick; cmd_snt = 1'b0;
        repeat (48) tick;
        checks++; if (done !== 4'b0)  begin errors++; $display("FAIL simul_early: got %b required 0000", done); end
        resp = 8'h5A; resp_rdy = 1'b1; tick; resp_rdy = 1'b0;
        checks++; if (done !== 4'b0010)   begin errors++; $display("FAIL simul_done: got %b required 0010", done); end
        checks++; if (resp_err !== 1'b0)  begin errors++; $display("FAIL simul_err: got %b required 0", resp_err); end
        checks++; if (resp_out !== 8'h5A) begin errors++; $display("FAIL simul_resp: got %h required 5a", resp_out); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [15:0] c; logic [3:0] g, d; logic [7:0] r; logic e;
        do_reset;
        req_cmd = {16'hBEEF, 16'h0000, 16'h0000, 16'h0101};
        req = 4'b0001;
        serve(1'b1, 8'h11, c, g, d, r, e);
        req = 4'b1000;
        wait_snd(n);
        tick;
        rst = 1'b1; req = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0 || done !== 4'b0) begin errors++; $display("FAIL mid_gnt_done: gnt=%b done=%b required 0000/0000", gnt, done); end
        checks++; if (busy !== 1'b0 || snd_cmd !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL mid_flags: busy=%b snd=%b err=%b required 0/0/0", busy, snd_cmd, resp_err); end
        checks++; if (cmd !== 16'h0000 || resp_out !== 8'h00) begin errors++; $display("FAIL mid_data: cmd=%h resp=%h required 0000/00", cmd, resp_out); end
        tick;
        rst = 1'b0; req = 4'b1001;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b required 0001", gnt); end
        rst = 1'b1; req = 4'b0000;
        tick;
        rst = 1'b0; req = 4'b0100;
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_regrant: got %b required 0100", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_no_wait;
        int n;
        do_reset;
        req_cmd0 = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        req0 = 4'b0100;
        tick;
        checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL nw_gnt: got %b required 0100", gnt0); end
        req0 = 4'b0000;
        n = 0;
        while (!snd_cmd0 && n < 20) begin tick; n++; end
        checks++; if (!snd_cmd0 || cmd0 !== 16'hFFFF) begin errors++; $display("FAIL nw_launch: snd=%b cmd=%h required 1/ffff", snd_cmd0, cmd0); end
        repeat (2) tick;
        cmd_snt0 = 1'b1; tick; cmd_snt0 = 1'b0;
        checks++; if (done0 !== 4'b0100)  begin errors++; $display("FAIL nw_done: got %b required 0100", done0); end
        checks++; if (resp_err0 !== 1'b0) begin errors++; $display("FAIL nw_err: got %b required 0", resp_err0); end
        tick;
        checks++; if (done0 !== 4'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL nw_after: done=%b busy=%b required 0000/0", done0, busy0); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_early_resp;
        test_reset_mid;
        test_no_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
